// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR conversion controller.
// Holds the controller state encoding, parameter defaults and the channel-width helper.
package sar_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_CONV   = 2'd2,
    S_DONE   = 2'd3
  } sar_state_e;

  localparam int SAR_WIDTH_DEF   = 12;
  localparam int SAR_NCH_DEF     = 4;
  localparam int SAR_TSAMP_DEF   = 2;
  localparam int SAR_TSETTLE_DEF = 1;

  // Wide enough for the largest TSAMP-1 (254) and TSETTLE-1 (14) reloads.
  localparam int SAR_TMR_W = 8;

  function automatic int sar_cw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/sar_timer.sv
// Loadable down-counter that stops at zero; zero_o is a decode of the count register.
// Load takes effect on the next edge; zero_o reflects the registered count.
module sar_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sar_ctrl_gen.sv
// Successive-approximation ADC sequencer: track, bit-by-bit trial/decide, result publish.
// conv_done rises TSAMP + WIDTH*TSETTLE + 1 cycles after start is accepted; all outputs registered.
module sar_ctrl_gen
  import sar_pkg::*;
#(
  parameter int  WIDTH   = SAR_WIDTH_DEF,
  parameter int  NCH     = SAR_NCH_DEF,
  parameter int  TSAMP   = SAR_TSAMP_DEF,
  parameter int  TSETTLE = SAR_TSETTLE_DEF,
  localparam int CW      = sar_cw(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic [CW-1:0]    ch_sel,
  input  logic             d,
  output logic             sample,
  output logic [CW-1:0]    ch_mux,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] bitout,
  output logic [CW-1:0]    bitout_ch,
  output logic             conv_done,
  output logic             busy,
  output logic             overrun
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [SAR_TMR_W-1:0] SAMP_LOAD = SAR_TMR_W'(TSAMP - 1);
  localparam logic [SAR_TMR_W-1:0] SETL_LOAD = SAR_TMR_W'(TSETTLE - 1);
  localparam logic [KW-1:0]        K_TOP     = KW'(WIDTH - 1);
  localparam logic [CW-1:0]        CH_LAST   = CW'(NCH - 1);
  localparam logic [WIDTH-1:0]     MSB_TRIAL = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_e         state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [CW-1:0]      ch_mux_q, ch_mux_d;
  logic [WIDTH-1:0]   dac_q, dac_d;
  logic [WIDTH-1:0]   bitout_q, bitout_d;
  logic [CW-1:0]      bitout_ch_q, bitout_ch_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               sample_q, sample_d;
  logic               overrun_q, overrun_d;

  logic                 tmr_load;
  logic [SAR_TMR_W-1:0] tmr_val;
  logic                 tmr_zero;

  // One timer serves both the track window and each per-bit settle window.
  sar_timer #(
    .TW(SAR_TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ch_mux_d    = ch_mux_q;
    dac_d       = dac_q;
    bitout_d    = bitout_q;
    bitout_ch_d = bitout_ch_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SAMPLE;
          ch_mux_d = CW'(int'(ch_sel) % NCH);
          dac_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = SAMP_LOAD;
        end
      end
      S_SAMPLE: begin
        if (tmr_zero) begin
          state_d  = S_CONV;
          k_d      = K_TOP;
          dac_d    = MSB_TRIAL;
          tmr_load = 1'b1;
          tmr_val  = SETL_LOAD;
        end
      end
      S_CONV: begin
        if (tmr_zero) begin
          dac_d[k_q] = d;
          if (k_q == '0) begin
            state_d     = S_DONE;
            bitout_d    = dac_d;
            bitout_ch_d = ch_mux_q;
            done_d      = 1'b1;
          end else begin
            // Decide this bit and raise the next trial bit on the same edge.
            dac_d[k_q - KW'(1)] = 1'b1;
            k_d                 = k_q - KW'(1);
            tmr_load            = 1'b1;
            tmr_val             = SETL_LOAD;
          end
        end
      end
      S_DONE: begin
        if (cont) begin
          state_d  = S_SAMPLE;
          ch_mux_d = (ch_mux_q == CH_LAST) ? '0 : ch_mux_q + CW'(1);
          dac_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = SAMP_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      k_d         = K_TOP;
      dac_d       = '0;
      bitout_d    = bitout_q;
      bitout_ch_d = bitout_ch_q;
      done_d      = 1'b0;
      tmr_load    = 1'b1;
      tmr_val     = '0;
    end
  end

  assign busy_d    = (state_d != S_IDLE);
  assign sample_d  = (state_d == S_SAMPLE);
  assign overrun_d = start && (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= K_TOP;
      ch_mux_q    <= '0;
      dac_q       <= '0;
      bitout_q    <= '0;
      bitout_ch_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      sample_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ch_mux_q    <= ch_mux_d;
      dac_q       <= dac_d;
      bitout_q    <= bitout_d;
      bitout_ch_q <= bitout_ch_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      sample_q    <= sample_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sample    = sample_q;
  assign ch_mux    = ch_mux_q;
  assign dac_code  = dac_q;
  assign bitout    = bitout_q;
  assign bitout_ch = bitout_ch_q;
  assign conv_done = done_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sar_ctrl_gen.sv
// Bench for sar_ctrl_gen: two configurations (12b/4ch/TSAMP2/TSETTLE1 and 8b/3ch/TSAMP1/TSETTLE3)
// driven by an ideal comparator and checked cycle by cycle against an arithmetic SAR model.
module tb_sar_ctrl_gen;

  logic clk;
  logic reset, cont, abort;
  logic start_a, start_b;
  logic [1:0] ch_sel;
  int   vin_a, vin_b;
  logic d_a, d_b;

  logic        sample_a, done_a, busy_a, ovr_a;
  logic [1:0]  ch_mux_a, bch_a;
  logic [11:0] dac_a, bitout_a;
  logic        sample_b, done_b, busy_b, ovr_b;
  logic [1:0]  ch_mux_b, bch_b;
  logic [7:0]  dac_b, bitout_b;

  int n_total = 0;
  int n_bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal comparator: 1 when the held input is at or above the DAC trial level.
  assign d_a = (vin_a >= int'(dac_a));
  assign d_b = (vin_b >= int'(dac_b));

  sar_ctrl_gen #(.WIDTH(12), .NCH(4), .TSAMP(2), .TSETTLE(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cont(cont), .abort(abort),
    .ch_sel(ch_sel), .d(d_a), .sample(sample_a), .ch_mux(ch_mux_a),
    .dac_code(dac_a), .bitout(bitout_a), .bitout_ch(bch_a),
    .conv_done(done_a), .busy(busy_a), .overrun(ovr_a)
  );

  sar_ctrl_gen #(.WIDTH(8), .NCH(3), .TSAMP(1), .TSETTLE(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cont(cont), .abort(abort),
    .ch_sel(ch_sel), .d(d_b), .sample(sample_b), .ch_mux(ch_mux_b),
    .dac_code(dac_b), .bitout(bitout_b), .bitout_ch(bch_b),
    .conv_done(done_b), .busy(busy_b), .overrun(ovr_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Trial code seen n cycles after start accept: upper bits follow the input, tried bit set.
  function automatic int trial_code(int v, int w, int ts, int tst, int n);
    int b;
    if (n <= ts) return 0;
    if (n > ts + w * tst) return v;
    b = w - 1 - (n - ts - 1) / tst;
    return ((v >> (b + 1)) << (b + 1)) | (1 << b);
  endfunction

  // One start-to-idle conversion with at most one injected event (busy start, abort or reset).
  task automatic conv(input bit inst, input int v, input int ch,
                      input int ovr_at, input int abort_at, input int rst_at);
    int w, ts, tst, nc, lat, ech, pbo, pbch;
    bit alive, rstd, abtd, fin;
    logic [31:0] o_smp, o_busy, o_done, o_ovr, o_dac, o_bo, o_bch, o_mux;
    w   = inst ? 8 : 12;
    ts  = inst ? 1 : 2;
    tst = inst ? 3 : 1;
    nc  = inst ? 3 : 4;
    lat = ts + w * tst + 1;
    ech = ch % nc;
    pbo  = inst ? int'(bitout_b) : int'(bitout_a);
    pbch = inst ? int'(bch_b) : int'(bch_a);
    if (inst) vin_b = v; else vin_a = v;

    @(negedge clk);
    ch_sel = 2'(ch);
    if (inst) start_b = 1'b1; else start_a = 1'b1;

    for (int n = 1; n <= lat + 3; n++) begin
      @(negedge clk);
      o_smp  = inst ? 32'(sample_b) : 32'(sample_a);
      o_busy = inst ? 32'(busy_b)   : 32'(busy_a);
      o_done = inst ? 32'(done_b)   : 32'(done_a);
      o_ovr  = inst ? 32'(ovr_b)    : 32'(ovr_a);
      o_dac  = inst ? 32'(dac_b)    : 32'(dac_a);
      o_bo   = inst ? 32'(bitout_b) : 32'(bitout_a);
      o_bch  = inst ? 32'(bch_b)    : 32'(bch_a);
      o_mux  = inst ? 32'(ch_mux_b) : 32'(ch_mux_a);

      rstd  = (rst_at >= 0) && (n > rst_at);
      abtd  = (abort_at >= 0) && (n > abort_at);
      alive = (n <= lat) && !rstd && !abtd;
      fin   = (n >= lat) && !(abort_at >= 0 && abort_at < lat) && !(rst_at >= 0 && rst_at < lat);

      check_eq($sformatf("sample%0d c%0d", inst, n), o_smp, 32'(alive && n <= ts));
      check_eq($sformatf("busy%0d c%0d", inst, n), o_busy, 32'(alive));
      check_eq($sformatf("done%0d c%0d", inst, n), o_done, 32'(alive && n == lat));
      check_eq($sformatf("overrun%0d c%0d", inst, n), o_ovr, 32'(ovr_at >= 1 && n == ovr_at + 1));
      check_eq($sformatf("bitout%0d c%0d", inst, n), o_bo, rstd ? 0 : (fin ? v : pbo));
      check_eq($sformatf("bitout_ch%0d c%0d", inst, n), o_bch, rstd ? 0 : (fin ? ech : pbch));
      if (alive) begin
        check_eq($sformatf("dac%0d c%0d", inst, n), o_dac, trial_code(v, w, ts, tst, n));
        check_eq($sformatf("ch_mux%0d c%0d", inst, n), o_mux, ech);
      end else if (rstd || abtd) begin
        check_eq($sformatf("dac_clr%0d c%0d", inst, n), o_dac, 0);
        if (rstd) check_eq($sformatf("ch_mux_rst%0d c%0d", inst, n), o_mux, 0);
      end

      start_a = 1'b0;
      start_b = 1'b0;
      abort   = 1'b0;
      reset   = 1'b0;
      ch_sel  = 2'(ch);
      if (n == ovr_at) begin
        ch_sel = 2'(ch + 1);
        if (inst) start_b = 1'b1; else start_a = 1'b1;
      end
      if (n == abort_at) abort = 1'b1;
      if (n == rst_at) reset = 1'b1;
    end
  endtask

  task automatic cont_test();
    int v, pulses;
    int pc[3];
    int pch[3];
    v = int'($urandom_range(0, 4095));
    vin_a = v;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      pc[i] = 0;
      pch[i] = 0;
    end
    @(negedge clk);
    cont = 1'b1;
    ch_sel = 2'd3;
    start_a = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (done_a) begin
        if (pulses < 3) begin
          pc[pulses] = n;
          pch[pulses] = int'(bch_a);
        end
        check_eq($sformatf("cont_bitout c%0d", n), 32'(bitout_a), v);
        pulses++;
        if (pulses == 3) cont = 1'b0;
      end
    end
    check_eq("cont_pulses", pulses, 3);
    check_eq("cont_first", pc[0], 15);
    check_eq("cont_gap1", pc[1] - pc[0], 15);
    check_eq("cont_gap2", pc[2] - pc[1], 15);
    check_eq("cont_ch0", pch[0], 3);
    check_eq("cont_ch1", pch[1], 0);
    check_eq("cont_ch2", pch[2], 1);
    check_eq("cont_idle", 32'(busy_a), 0);
  endtask

  initial begin
    int inst, w, lat, v, ch, kind, at;
    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    cont = 1'b0;
    abort = 1'b0;
    ch_sel = 2'd0;
    vin_a = 0;
    vin_b = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_sample", 32'(sample_a), 0);
    check_eq("rst_busy", 32'(busy_a), 0);
    check_eq("rst_dac", 32'(dac_a), 0);
    check_eq("rst_bitout", 32'(bitout_a), 0);
    check_eq("rst_bitout_ch", 32'(bch_a), 0);
    check_eq("rst_ch_mux", 32'(ch_mux_a), 0);
    check_eq("rst_done", 32'(done_a), 0);
    check_eq("rst_overrun", 32'(ovr_a), 0);
    check_eq("rst_b_busy", 32'(busy_b), 0);
    check_eq("rst_b_dac", 32'(dac_b), 0);
    reset = 1'b0;

    conv(0, 'hA5C, 2, -1, -1, -1);
    conv(0, 'hFFF, 1, -1, -1, -1);
    conv(0, 'h000, 0, -1, -1, -1);
    conv(0, 'h3C7, 1, 4, -1, -1);
    conv(0, 'h123, 3, 15, -1, -1);
    conv(0, 'h5A5, 2, -1, 7, -1);
    conv(0, 'h777, 3, -1, -1, 5);
    conv(1, 'hB3, 3, -1, -1, -1);
    conv(1, 'h4E, 1, 10, -1, -1);
    conv(1, 'hFF, 2, -1, 14, -1);
    cont_test();

    for (int i = 0; i < 10; i++) begin
      inst = int'($urandom_range(0, 1));
      w    = (inst != 0) ? 8 : 12;
      lat  = (inst != 0) ? 26 : 15;
      v    = int'($urandom_range(0, (1 << w) - 1));
      ch   = int'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 3));
      at   = int'($urandom_range(1, lat));
      conv(inst != 0, v, ch, (kind == 1) ? at : -1, (kind == 2) ? at : -1, (kind == 3) ? at : -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
